// File: rtl/mpu_upload_master.sv
// Loads MPU BRAM (port A) from the APF bridge through a small write FIFO while the MPU is held in reset; run bit releases it.
// Writes reach BRAM two cycles after the strobe, one per cycle; RAM readback only with `define MPU_UPLOAD_READBACK_EN.
module mpu_upload_master #(
  parameter logic [7:0] BASE_HI    = 8'h80,
  parameter logic [7:0] CTRL_HI    = 8'h81,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic        mpu_reset_n,
  output logic        bram_request,
  output logic        bram_write,
  output logic [23:0] bram_address,
  output logic [3:0]  bram_mask,
  output logic [31:0] bram_data_out,
  input  logic        bram_valid,
  input  logic [31:0] bram_data_in
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          EW      = 54;
  localparam logic [AW:0] PTR_ONE = 1;

`ifdef MPU_UPLOAD_READBACK_EN
  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t        state, state_nxt;
  logic          run;
  logic [7:0]    drop_count;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          fifo_empty, fifo_full, push, pop, wr_drop, rd_drop, read_busy;
  logic          ram_hit, ctrl_hit;
  logic          req_nxt, wr_nxt;
  logic [23:0]   addr_nxt;
  logic [3:0]    mask_nxt;
  logic [31:0]   data_nxt, ctrl_rdata;

  assign ram_hit     = (bridge_addr[31:24] == BASE_HI);
  assign ctrl_hit    = (bridge_addr[31:24] == CTRL_HI);
  assign mpu_reset_n = run;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign push       = bridge_wr && ram_hit && !run && !fifo_full;
  assign wr_drop    = bridge_wr && ram_hit && !push;

`ifdef MPU_UPLOAD_READBACK_EN
  logic        rd_pend, rd_accept, rd_done;
  logic [21:0] rd_addr;
  logic        unused_bits;

  // A second read while one is pending or in flight is dropped, not queued.
  assign rd_accept   = bridge_rd && ram_hit && !rd_pend && !run;
  assign rd_drop     = bridge_rd && ram_hit && !rd_accept;
  assign read_busy   = rd_pend;
  assign unused_bits = ^bridge_addr[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else if (rd_accept) begin
      rd_pend <= 1'b1;
      rd_addr <= bridge_addr[23:2];
    end else if (rd_done) begin
      rd_pend <= 1'b0;
    end
  end
`else
  logic unused_bits;
  assign rd_drop     = 1'b0;
  assign read_busy   = 1'b0;
  assign unused_bits = ^{bridge_addr[1:0], bram_valid, bram_data_in};
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {bridge_addr[23:2], bswap(bridge_wr_data)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      run        <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (bridge_wr && ctrl_hit && bridge_addr[23:2] == 22'd0) run <= bridge_wr_data[0];
      if ((wr_drop || rd_drop) && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Outputs are computed here and registered below, so each state's strobe appears the cycle after it is chosen.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    req_nxt   = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = bram_address;
    mask_nxt  = bram_mask;
    data_nxt  = bram_data_out;
`ifdef MPU_UPLOAD_READBACK_EN
    rd_done   = 1'b0;
`endif
    case (state)
      IDLE, WRITE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WRITE;
          req_nxt   = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = {head[EW-1:32], 2'b00};
          mask_nxt  = 4'hF;
          data_nxt  = head[31:0];
`ifdef MPU_UPLOAD_READBACK_EN
        end else if (state == IDLE && rd_pend && !run) begin
          state_nxt = RD_ISSUE;
          req_nxt   = 1'b1;
          addr_nxt  = {rd_addr, 2'b00};
          mask_nxt  = 4'hF;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
`ifdef MPU_UPLOAD_READBACK_EN
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (bram_valid) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bram_request  <= 1'b0;
      bram_write    <= 1'b0;
      bram_address  <= '0;
      bram_mask     <= '0;
      bram_data_out <= '0;
    end else begin
      bram_request  <= req_nxt;
      bram_write    <= wr_nxt;
      bram_address  <= addr_nxt;
      bram_mask     <= mask_nxt;
      bram_data_out <= data_nxt;
    end
  end

  always_comb begin
    ctrl_rdata = '0;
    if (ctrl_hit && bridge_addr[23:2] == 22'd0) ctrl_rdata = {31'd0, run};
    if (ctrl_hit && bridge_addr[23:2] == 22'd1) ctrl_rdata = {22'd0, read_busy, fifo_empty, drop_count};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bridge_rd_data <= '0;
`ifdef MPU_UPLOAD_READBACK_EN
    end else if (rd_done) begin
      bridge_rd_data <= bswap(bram_data_in);
    end else if (bridge_rd && !ram_hit) begin
`else
    end else if (bridge_rd) begin
`endif
      bridge_rd_data <= ctrl_rdata;
    end
  end

endmodule

// File: tb/tb_mpu_upload_master.sv
`timescale 1ns/1ps
module tb_mpu_upload_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bridge_addr = '0;
  logic        bridge_wr = 1'b0;
  logic [31:0] bridge_wr_data = '0;
  logic        bridge_rd = 1'b0;
  logic [31:0] bridge_rd_data;
  logic        mpu_reset_n;
  logic        bram_request, bram_write;
  logic [23:0] bram_address;
  logic [3:0]  bram_mask;
  logic [31:0] bram_data_out;
  logic        bram_valid = 1'b0;
  logic [31:0] bram_data_in = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [23:0] o_addr[$];
  logic [31:0] o_data[$];
  logic        o_wr[$];
  int          o_cyc[$];
  logic [31:0] mem[logic [23:0]];

  localparam logic [31:0] CTRL   = 32'h8100_0000;
  localparam logic [31:0] STATUS = 32'h8100_0004;

  mpu_upload_master dut (
    .clk(clk), .reset_n(reset_n),
    .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
    .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
    .mpu_reset_n(mpu_reset_n),
    .bram_request(bram_request), .bram_write(bram_write), .bram_address(bram_address),
    .bram_mask(bram_mask), .bram_data_out(bram_data_out),
    .bram_valid(bram_valid), .bram_data_in(bram_data_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: writes store data_out as-is, reads answer one cycle after the request.
  always @(posedge clk) begin
    bram_valid <= 1'b0;
    if (bram_request) begin
      if (bram_write) mem[bram_address] = bram_data_out;
      else begin
        bram_valid   <= 1'b1;
        bram_data_in <= mem.exists(bram_address) ? mem[bram_address] : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bram_request) begin
      o_addr.push_back(bram_address);
      o_data.push_back(bram_data_out);
      o_wr.push_back(bram_write);
      o_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
    tick();
    bridge_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    bridge_addr = a; bridge_rd = 1'b1;
    tick();
    bridge_rd = 1'b0;
  endtask

  task automatic clear_log();
    o_addr.delete(); o_data.delete(); o_wr.delete(); o_cyc.delete();
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; bridge_wr = 1'b0; bridge_rd = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_mpu_reset_n", 32'(mpu_reset_n), 32'h0);
    check("rst_req", 32'(bram_request), 32'h0);
    check("rst_wr", 32'(bram_write), 32'h0);
    check("rst_addr", 32'(bram_address), 32'h0);
    check("rst_mask", 32'(bram_mask), 32'h0);
    check("rst_data", bram_data_out, 32'h0);
    check("rst_rd_data", bridge_rd_data, 32'h0);
    reset_n = 1'b1;
    tick();
    bus_read(STATUS);
    check("rst_status", bridge_rd_data, 32'h0000_0100);
    bus_read(CTRL);
    check("rst_ctrl", bridge_rd_data, 32'h0);

    // Single write: strobe in N, BRAM write in N+2 only
    clear_log();
    bus_write(32'h8000_0010, 32'h1122_3344);
    check("wr_n1_req", 32'(bram_request), 32'h0);
    tick();
    check("wr_n2_req", 32'(bram_request), 32'h1);
    check("wr_n2_wr", 32'(bram_write), 32'h1);
    check("wr_n2_addr", 32'(bram_address), 32'h0000_0010);
    check("wr_n2_data", bram_data_out, 32'h4433_2211);
    check("wr_n2_mask", 32'(bram_mask), 32'hF);
    tick();
    check("wr_n3_req", 32'(bram_request), 32'h0);
    repeat (3) tick();
    check("wr_pulses", 32'(o_addr.size()), 32'd1);

    // Burst of 8 back-to-back writes
    clear_log();
    for (int i = 0; i < 8; i++) bus_write(32'h8000_0000 + 32'(4 * i), {8'(i), 24'hA0B0C0});
    repeat (6) tick();
    check("burst_cnt", 32'(o_addr.size()), 32'd8);
    for (int i = 0; i < o_addr.size() && i < 8; i++) begin
      check($sformatf("burst_addr%0d", i), 32'(o_addr[i]), 32'(4 * i));
      check($sformatf("burst_data%0d", i), o_data[i], {24'hC0B0A0, 8'(i)});
      check($sformatf("burst_wr%0d", i), 32'(o_wr[i]), 32'h1);
      check($sformatf("burst_cyc%0d", i), 32'(o_cyc[i] - o_cyc[0]), 32'(i));
    end
    bus_read(STATUS);
    check("burst_status", bridge_rd_data, 32'h0000_0100);

`ifdef MPU_UPLOAD_READBACK_EN
    // Readback right behind a write observes the write
    clear_log();
    bus_write(32'h8000_0100, 32'hDEAD_BEEF);
    bus_read(32'h8000_0100);
    repeat (8) tick();
    check("rb_data", bridge_rd_data, 32'hDEAD_BEEF);
    check("rb_reqs", 32'(o_addr.size()), 32'd2);
    if (o_addr.size() == 2) begin
      check("rb_rd_wr", 32'(o_wr[1]), 32'h0);
      check("rb_rd_addr", 32'(o_addr[1]), 32'h0000_0100);
    end

    // Double read: second one dropped; latency N+2 request, N+4 data
    clear_log();
    bus_read(32'h8000_0010);
    bus_read(32'h8000_0000);
    check("dr_n2_req", 32'(bram_request), 32'h1);
    check("dr_n2_wr", 32'(bram_write), 32'h0);
    check("dr_n2_addr", 32'(bram_address), 32'h0000_0010);
    tick();
    check("dr_n3_data", bridge_rd_data, 32'hDEAD_BEEF);
    tick();
    check("dr_n4_data", bridge_rd_data, 32'h04A0_B0C0);
    repeat (4) tick();
    check("dr_reqs", 32'(o_addr.size()), 32'd1);
    bus_read(STATUS);
    check("dr_status", bridge_rd_data, 32'h0000_0101);
`else
    // RAM reads answer 0 at N+1 with no BRAM traffic and no drop
    bus_read(STATUS);
    check("ramrd_pre", bridge_rd_data, 32'h0000_0100);
    clear_log();
    bus_read(32'h8000_0010);
    check("ramrd_zero", bridge_rd_data, 32'h0);
    repeat (4) tick();
    check("ramrd_nobram", 32'(o_addr.size()), 32'd0);
    bus_read(STATUS);
    check("ramrd_status", bridge_rd_data, 32'h0000_0100);
`endif

    // Run gating and drop saturation
    reset_dut();
    bus_write(CTRL, 32'h1);
    check("run_mpu_reset_n", 32'(mpu_reset_n), 32'h1);
    clear_log();
    bus_write(32'h8000_0020, 32'h0000_0055);
    repeat (4) tick();
    check("run_nobram", 32'(o_addr.size()), 32'd0);
    bus_read(STATUS);
    check("run_status", bridge_rd_data, 32'h0000_0101);
    bus_read(CTRL);
    check("run_ctrl", bridge_rd_data, 32'h1);
    for (int i = 0; i < 300; i++) bus_write(32'h8000_0000, 32'(i));
    bus_read(STATUS);
    check("drop_saturate", bridge_rd_data, 32'h0000_01FF);
    bus_write(CTRL, 32'h0);
    check("run_clear", 32'(mpu_reset_n), 32'h0);

    // Reset in the middle of a 4-word burst
    reset_dut();
    bus_write(32'h8000_0040, 32'hAAAA_0000);
    bus_write(32'h8000_0044, 32'hAAAA_0001);
    bus_write(32'h8000_0048, 32'hAAAA_0002);
    bridge_addr = 32'h8000_004C; bridge_wr_data = 32'hAAAA_0003; bridge_wr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_req", 32'(bram_request), 32'h0);
    check("mid_wr", 32'(bram_write), 32'h0);
    check("mid_addr", 32'(bram_address), 32'h0);
    check("mid_data", bram_data_out, 32'h0);
    check("mid_mask", 32'(bram_mask), 32'h0);
    check("mid_mpu_reset_n", 32'(mpu_reset_n), 32'h0);
    bridge_wr = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    clear_log();
    repeat (6) tick();
    check("mid_noreq", 32'(o_addr.size()), 32'd0);
    bus_read(STATUS);
    check("mid_status", bridge_rd_data, 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mpu_upload_master.md
# mpu_upload_master

Bus-master front end that loads MPU program/data RAM from the APF bridge while the MPU is held in reset, then releases it. It drives the data-side port (port A) of the MPU's 32-bit dual-port BRAM block. That port uses a request/write/mask protocol with a fixed one-cycle `bram_valid` response. The block buffers bridge writes in a small FIFO, converts them from big-endian to little-endian, and sequences them onto the BRAM port. It also services bridge readback and owns the MPU reset line.

## Interface
Parameters:
- `BASE_HI`, default 8'h80: `bridge_addr[31:24]` value that selects the RAM upload window (16 MB, word-addressed).
- `CTRL_HI`, default 8'h81: `bridge_addr[31:24]` value that selects the control/status registers.
- `FIFO_DEPTH`, default 4: write FIFO entries; power of two, minimum 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; BRAM and bridge are both synchronous to it.
- `reset_n` in 1: asynchronous active-low reset.
- `bridge_addr` in 32: APF bridge address.
- `bridge_wr` in 1: one-cycle write strobe.
- `bridge_wr_data` in 32: write data, big-endian.
- `bridge_rd` in 1: one-cycle read strobe.
- `bridge_rd_data` out 32: read data, big-endian; held until the next read completes.
- `mpu_reset_n` out 1: reset to the MPU core; low = held.
- `bram_request` out 1: access strobe.
- `bram_write` out 1: write qualifier, valid only with `bram_request`.
- `bram_address` out 24: byte address; bits [1:0] always 0.
- `bram_mask` out 4: byte enables.
- `bram_data_out` out 32: write data, little-endian.
- `bram_valid` in 1: read data valid, one cycle after `bram_request`.
- `bram_data_in` in 32: read data.

## Operation
- **Address decode:**
  - RAM window hit: `bridge_addr[31:24]==BASE_HI`; BRAM byte address = `{bridge_addr[23:2],2'b00}`.
  - CTRL window hit: `bridge_addr[31:24]==CTRL_HI`. Offset 0x0 is CTRL; bit0 = run; writes set it, reads return it. Offset 0x4 is STATUS (read-only): [7:0] drop_count, [8] fifo_empty, [9] read_busy.
  - Other addresses are ignored; reads of them return 0.
- **`mpu_reset_n`:** equals the CTRL run bit. Writing run=0 re-asserts reset on the next cycle.
- **RAM writes:**
  - Accepted only when run=0 and the FIFO is not full. Entry = {address, byte-swapped data}; mask is always 4'hF.
  - Rejected (run=1, or FIFO full): dropped, and drop_count increments, saturating at 255.
- **FSM states:** IDLE, WRITE, RD_ISSUE, RD_WAIT.
  - IDLE → WRITE when the FIFO is non-empty. Otherwise IDLE → RD_ISSUE when a read is pending.
  - WRITE pops one entry per cycle with `bram_request=bram_write=1`. It stays in WRITE while the FIFO is non-empty, then returns to IDLE.
  - RD_ISSUE drives one cycle of `bram_request=1, bram_write=0`, then goes to RD_WAIT.
  - RD_WAIT captures `bram_data_in` byte-swapped into `bridge_rd_data` when `bram_valid`=1, then returns to IDLE.
- **Ordering:** a pending read waits until the FIFO drains, so reads observe all earlier writes.
- **RAM reads:** a RAM-window `bridge_rd` sets a pending read. If a read is already pending or in flight, the new read is dropped and drop_count increments.
- **CTRL reads:** answered directly from registers, independent of the FSM.
- **Simultaneous FIFO push and pop:** allowed; occupancy is unchanged.
- **BRAM port while run=1:** no BRAM accesses are issued. FIFO contents remaining when run is set are still drained.

## Timing
- **Reset values:**
  - `mpu_reset_n`=0, run=0.
  - `bram_request`=0, `bram_write`=0, `bram_address`=0, `bram_mask`=0, `bram_data_out`=0.
  - `bridge_rd_data`=0, drop_count=0.
  - FIFO empty, FSM in IDLE.
- **Reset mid-operation:** FIFO contents and any pending read are discarded with no further BRAM strobe.
- **Write latency:** `bridge_wr` in cycle N with an empty FIFO gives `bram_request` in N+2 (N+1 FIFO write, N+2 registered output).
- **Write throughput:** one word per cycle.
- **RAM read latency:** `bridge_rd` in cycle N with an idle FSM and empty FIFO gives `bram_request` in N+2, `bram_valid` in N+3, `bridge_rd_data` updated in N+4. The bridge samples no earlier than N+5.
- **CTRL read latency:** `bridge_rd_data` updated in N+1.
- **Run-bit latency:** a CTRL write in cycle N changes `mpu_reset_n` in cycle N+1.

## Configuration
- `MPU_UPLOAD_READBACK_EN` defined: RAM-window readback via RD_ISSUE/RD_WAIT as above.
- Not defined:
  - RD_ISSUE and RD_WAIT are removed; `bram_write` is 1 whenever `bram_request` is 1.
  - RAM-window reads return 32'h0 at N+1 and never touch drop_count.
  - CTRL/STATUS reads are unchanged; read_busy reads 0.

## Test plan
- **Single write:** reset, then write 0x80000010 ← 0x11223344. Expect `bram_address`=0x000010, `bram_data_out`=0x44332211, `bram_mask`=F, `bram_write`=1 at N+2, one cycle wide.
- **Burst:** 8 back-to-back writes at 0x80000000–0x8000001C. Expect 8 consecutive `bram_request` pulses, in order, no drops, drop_count=0.
- **Readback** (macro on): write 0xDEADBEEF to 0x80000100, then read it on the next cycle. Expect `bridge_rd_data`=0xDEADBEEF after the write strobe has completed.
- **Run gating:** write 1 to 0x81000000. Expect `mpu_reset_n`=1 at N+1. A subsequent RAM write produces no `bram_request`, and STATUS reads drop_count=1.
- **Double read:** two RAM reads 1 cycle apart. Expect only one `bram_request`, drop_count=1.
- **Mid-burst reset:** assert `reset_n` low during a 4-word burst. Expect all outputs at reset values immediately, and no `bram_request` after release.
